alu: RTL and testbench

32-bit integer ALU for the MIPS CPU datapath. It takes two 32-bit operands and a 3-bit operation code, and produces a registered result plus three flags: zero, signed overflow, and a sign test on A used by the BGEZAL branch. The block sits between the register-file/immediate muxes and the writeback/branch logic, and adds one pipeline register stage.

---
 rtl/alu_if.sv | 14 +
 rtl/alu.sv | 62 ++++++
 tb/tb_alu.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// alu_if: operand/opcode/result bundle between the datapath muxes and the ALU.
//   master drives ALUOp, A, B and receives alu_res, zero, overflow, bgezal_flag;
//   slave is the reverse view used by the ALU itself.
interface alu_if;
    logic [2:0]  ALUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] alu_res;
    logic        zero;
    logic        overflow;
    logic        bgezal_flag;
    modport master (output ALUOp, A, B, input alu_res, zero, overflow, bgezal_flag);
    modport slave  (input ALUOp, A, B, output alu_res, zero, overflow, bgezal_flag);
endinterface

// File: rtl/alu.sv
// alu: 32-bit MIPS integer ALU with a single output register stage.
//   clk, rst (sync, active-high) plain ports; bus (alu_if.slave) carries
//   ALUOp/A/B in and registered alu_res/zero/overflow/bgezal_flag out.
module alu (
    input logic   clk,
    input logic   rst,
    alu_if.slave  bus
);
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_slt;
    logic        w_sltu;
    logic [31:0] w_res;
    logic        w_ovf;
    logic [31:0] r_res;
    logic        r_zero;
    logic        r_ovf;
    logic        r_bgez;
    assign w_sum  = bus.A + bus.B;
    assign w_diff = bus.A - bus.B;
    // Full comparisons, so SLT stays correct when A - B overflows.
    assign w_slt  = $signed(bus.A) < $signed(bus.B);
    assign w_sltu = bus.A < bus.B;
    always_comb begin
        w_res = 32'h0;
        w_ovf = 1'b0;
        case (bus.ALUOp)
            3'b000: begin
                w_res = w_sum;
                w_ovf = (bus.A[31] == bus.B[31]) && (w_sum[31] != bus.A[31]);
            end
            3'b001: begin
                w_res = w_diff;
                w_ovf = (bus.A[31] != bus.B[31]) && (w_diff[31] != bus.A[31]);
            end
            3'b010:  w_res = bus.A | bus.B;
            3'b011:  w_res = {31'h0, w_slt};
            3'b100:  w_res = bus.A & bus.B;
            3'b101:  w_res = {31'h0, w_sltu};
            3'b110:  w_res = bus.A ^ bus.B;
            default: w_res = ~(bus.A | bus.B);
        endcase
    end
    // Reset leaves zero=1 so the flag agrees with the cleared result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res  <= 32'h0;
            r_zero <= 1'b1;
            r_ovf  <= 1'b0;
            r_bgez <= 1'b0;
        end else begin
            r_res  <= w_res;
            r_zero <= (w_res == 32'h0);
            r_ovf  <= w_ovf;
            r_bgez <= ~bus.A[31];
        end
    end
    assign bus.alu_res     = r_res;
    assign bus.zero        = r_zero;
    assign bus.overflow    = r_ovf;
    assign bus.bgezal_flag = r_bgez;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and random-operand self-checking bench for alu.
module tb_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    alu_if bus ();
    alu dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [34:0] obs();
        return {bus.alu_res, bus.zero, bus.overflow, bus.bgezal_flag};
    endfunction
    // Reference model built on 64-bit signed arithmetic, returns {res,zero,ovf,bgez}.
    function automatic logic [34:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        logic [31:0] r;
        logic ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ov = 1'b0;
        s  = 0;
        case (op)
            3'd0: begin s = sa + sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd1: begin s = sa - sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd2: r = a | b;
            3'd3: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd4: r = a & b;
            3'd5: r = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            3'd6: r = a ^ b;
            default: r = ~(a | b);
        endcase
        return {r, r == 32'd0, ov, ~a[31]};
    endfunction
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.ALUOp = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        logic [34:0] got;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(3'b000, 32'hFFFF_FFFF, 32'h1);
            got = obs();
            checks++;
            if (got !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_%0d: got res=%h z=%b ov=%b bg=%b exp res=00000000 z=1 ov=0 bg=0", i, got[34:3], got[2], got[1], got[0]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        got = obs();
        checks++;
        if (got !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release: got res=%h z=%b ov=%b bg=%b exp res=00000000 z=1 ov=0 bg=0", got[34:3], got[2], got[1], got[0]);
        end
    endtask
    task automatic test_slt();
        logic [34:0] got;
        drive(3'b011, 32'hFFFF_FFFF, 32'h1);
        got = obs();
        checks++;
        if (got !== {32'h1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL slt_neg: got res=%h z=%b ov=%b bg=%b exp res=00000001 z=0 ov=0 bg=0", got[34:3], got[2], got[1], got[0]);
        end
        drive(3'b101, 32'hFFFF_FFFF, 32'h1);
        got = obs();
        checks++;
        if (got !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sltu_big: got res=%h z=%b ov=%b bg=%b exp res=00000000 z=1 ov=0 bg=0", got[34:3], got[2], got[1], got[0]);
        end
    endtask
    task automatic test_add();
        logic [34:0] got;
        drive(3'b000, 32'h7FFF_FFFF, 32'h1);
        got = obs();
        checks++;
        if (got !== {32'h8000_0000, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL add_ovf: got res=%h z=%b ov=%b bg=%b exp res=80000000 z=0 ov=1 bg=1", got[34:3], got[2], got[1], got[0]);
        end
        drive(3'b000, 32'd3, 32'd4);
        got = obs();
        checks++;
        if (got !== {32'd7, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_small: got res=%h z=%b ov=%b bg=%b exp res=00000007 z=0 ov=0 bg=1", got[34:3], got[2], got[1], got[0]);
        end
    endtask
    task automatic test_logic();
        logic [2:0]  ops [5] = '{3'b010, 3'b010, 3'b100, 3'b110, 3'b111};
        logic [31:0] as  [5] = '{32'd3, 32'd5, 32'd5, 32'd5, 32'd0};
        logic [31:0] bs  [5] = '{32'd4, 32'd4, 32'd4, 32'd4, 32'd0};
        logic [31:0] exp [5] = '{32'd7, 32'd5, 32'd4, 32'd1, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], as[i], bs[i]);
            checks++;
            if (bus.alu_res !== exp[i] || bus.zero !== 1'b0 || bus.overflow !== 1'b0) begin
                errors++;
                $display("FAIL logic_%0d: got res=%h z=%b ov=%b exp res=%h z=0 ov=0", i, bus.alu_res, bus.zero, bus.overflow, exp[i]);
            end
        end
    endtask
    task automatic test_sub();
        logic [34:0] got;
        drive(3'b001, 32'h8000_0000, 32'h1);
        got = obs();
        checks++;
        if (got !== {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_ovf: got res=%h z=%b ov=%b bg=%b exp res=7fffffff z=0 ov=1 bg=0", got[34:3], got[2], got[1], got[0]);
        end
        drive(3'b011, 32'h8000_0000, 32'h1);
        got = obs();
        checks++;
        if (got !== {32'h1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL slt_edge: got res=%h z=%b ov=%b bg=%b exp res=00000001 z=0 ov=0 bg=0", got[34:3], got[2], got[1], got[0]);
        end
    endtask
    task automatic test_hold_and_midreset();
        logic [34:0] got;
        drive(3'b000, 32'd10, 32'd20);
        bus.A = 32'hDEAD_BEEF;
        bus.ALUOp = 3'b111;
        #2;
        got = obs();
        checks++;
        if (got !== {32'd30, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL hold: got res=%h z=%b ov=%b bg=%b exp res=0000001e z=0 ov=0 bg=1", got[34:3], got[2], got[1], got[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(3'b010, 32'h1234, 32'h1);
        rst = 1'b0;
        got = obs();
        checks++;
        if (got !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset: got res=%h z=%b ov=%b bg=%b exp res=00000000 z=1 ov=0 bg=0", got[34:3], got[2], got[1], got[0]);
        end
    endtask
    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [34:0] exp;
        for (int i = 0; i < 240; i++) begin
            op = 3'(i % 8);
            a  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            b  = (i % 7 == 0) ? a : $urandom;
            if (i % 11 == 0) b = 32'h7FFF_FFFF;
            exp = model(op, a, b);
            drive(op, a, b);
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL b2b_%0d op=%0d a=%h b=%h: got %h exp %h", i, op, a, b, obs(), exp);
            end
        end
    endtask
    initial begin
        bus.ALUOp = 3'b000;
        bus.A     = 32'h0;
        bus.B     = 32'h0;
        test_reset();
        test_slt();
        test_add();
        test_logic();
        test_sub();
        test_hold_and_midreset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
